// File: rtl/h264_pkg.sv
// rtl/h264_pkg.sv - shared constants and types for the macroblock pixel fetch path
package h264_pkg;

  localparam int MB_SIZE       = 16;
  localparam int PIX_W         = 8;
  localparam int WORDS_PER_ROW = 4;

  typedef logic [WORDS_PER_ROW*PIX_W-1:0] pix4_t;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } fetch_state_t;

  // Position tags travel with each word so the consumer never re-derives the scan position.
  typedef struct packed {
    logic [3:0] row;
    logic [1:0] col;
    logic       last_mb;
    logic       last_frame;
  } fetch_tag_t;

endpackage

// File: rtl/mb_pixel_fetch_if.sv
// rtl/mb_pixel_fetch_if.sv - tagged pixel-word stream from the fetch block to the front end
interface mb_pixel_fetch_if;
  import h264_pkg::*;

  pix4_t      data;
  logic       valid;
  logic       ready;
  logic [3:0] row;
  logic [1:0] col;
  logic       last_mb;
  logic       last_frame;

  modport master (
    output data, valid, row, col, last_mb, last_frame,
    input  ready
  );

  modport slave (
    input  data, valid, row, col, last_mb, last_frame,
    output ready
  );

endinterface

// File: rtl/fifo2_tagged.sv
// rtl/fifo2_tagged.sv - 2-entry show-ahead FIFO holding a pixel word and its scan tags
module fifo2_tagged
  import h264_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic       push,
  input  pix4_t      push_data,
  input  fetch_tag_t push_tag,
  input  logic       pop,
  output pix4_t      head_data,
  output fetch_tag_t head_tag,
  output logic [1:0] count
);

  pix4_t      data_q [2];
  fetch_tag_t tag_q  [2];
  logic       wr_ptr;
  logic       rd_ptr;

  // The caller's credit scheme guarantees no push when full and no pop when empty.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_q[0] <= '0;
      data_q[1] <= '0;
      tag_q[0]  <= '0;
      tag_q[1]  <= '0;
      wr_ptr    <= 1'b0;
      rd_ptr    <= 1'b0;
      count     <= 2'd0;
    end else begin
      if (push) begin
        data_q[wr_ptr] <= push_data;
        tag_q[wr_ptr]  <= push_tag;
        wr_ptr         <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end

  assign head_data = data_q[rd_ptr];
  assign head_tag  = tag_q[rd_ptr];

endmodule

// File: rtl/mb_pixel_fetch.sv
// rtl/mb_pixel_fetch.sv - walks a raster luma frame in macroblock order and streams packed words
module mb_pixel_fetch
  import h264_pkg::*;
#(
  parameter int  WIDTH  = 352,
  parameter int  HEIGHT = 288,
  localparam int ADDR_W = $clog2(WIDTH*HEIGHT/4)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  pix4_t             mem_rdata,
  mb_pixel_fetch_if.master  out_s
);

  localparam int MBW   = WIDTH / MB_SIZE;
  localparam int MBH   = HEIGHT / MB_SIZE;
  localparam int WPR   = WIDTH / WORDS_PER_ROW;
  localparam int MBX_W = (MBW > 1) ? $clog2(MBW) : 1;
  localparam int MBY_W = (MBH > 1) ? $clog2(MBH) : 1;

  if (WIDTH % MB_SIZE != 0) begin : g_bad_width
    $error("mb_pixel_fetch: WIDTH must be a multiple of 16");
  end
  if (HEIGHT % MB_SIZE != 0) begin : g_bad_height
    $error("mb_pixel_fetch: HEIGHT must be a multiple of 16");
  end

  fetch_state_t      state;
  logic [1:0]        col;
  logic [3:0]        row;
  logic [MBX_W-1:0]  mb_x;
  logic [MBY_W-1:0]  mb_y;
  logic [ADDR_W-1:0] mb_base;
  logic [ADDR_W-1:0] row_addr;
  logic [ADDR_W-1:0] next_mb_base;
  logic              inflight;
  fetch_tag_t        inflight_tag;
  fetch_tag_t        issue_tag;
  fetch_tag_t        head_tag;
  pix4_t             head_data;
  logic [1:0]        fifo_count;
  logic [2:0]        credits_used;
  logic              pop;
  logic              accept;
  logic              last_mb_x;
  logic              last_mb_y;
  logic              last_in_mb;
  logic              last_word;

  assign pop        = out_s.valid && out_s.ready;
  assign accept     = (state == IDLE) && start && !done;
  assign last_mb_x  = (mb_x == MBX_W'(MBW - 1));
  assign last_mb_y  = (mb_y == MBY_W'(MBH - 1));
  assign last_in_mb = (row == 4'd15) && (col == 2'd3);
  assign last_word  = last_in_mb && last_mb_x && last_mb_y;
  assign issue_tag  = {row, col, last_in_mb, last_word};

  // Credits span the FIFO plus the one read whose data is on mem_rdata this cycle;
  // counting the pop lets a full pipeline keep issuing one word per cycle.
  assign credits_used = {1'b0, fifo_count} + {2'b0, inflight} - {2'b0, pop};
  assign mem_rd_en    = (state == RUN) && (credits_used < 3'd2);
  assign mem_addr     = row_addr + ADDR_W'(col);

  // Row 15 of the rightmost MB plus one word lands exactly on the next MB row's origin.
  assign next_mb_base = last_mb_x ? row_addr + ADDR_W'(WORDS_PER_ROW)
                                  : mb_base + ADDR_W'(WORDS_PER_ROW);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      col      <= '0;
      row      <= '0;
      mb_x     <= '0;
      mb_y     <= '0;
      mb_base  <= '0;
      row_addr <= '0;
    end else if (accept) begin
      col      <= '0;
      row      <= '0;
      mb_x     <= '0;
      mb_y     <= '0;
      mb_base  <= '0;
      row_addr <= '0;
    end else if (mem_rd_en) begin
      if (col != 2'd3) begin
        col <= col + 2'd1;
      end else begin
        col <= '0;
        if (row != 4'd15) begin
          row      <= row + 4'd1;
          row_addr <= row_addr + ADDR_W'(WPR);
        end else begin
          row      <= '0;
          mb_x     <= last_mb_x ? '0 : mb_x + MBX_W'(1);
          mb_y     <= last_mb_x ? mb_y + MBY_W'(1) : mb_y;
          mb_base  <= next_mb_base;
          row_addr <= next_mb_base;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      inflight     <= 1'b0;
      inflight_tag <= '0;
    end else begin
      inflight <= mem_rd_en;
      if (mem_rd_en) begin
        inflight_tag <= issue_tag;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            state <= RUN;
            busy  <= 1'b1;
          end
        end
        RUN: begin
          if (mem_rd_en && last_word) begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          // Finishes on the edge that accepts the final word.
          if (!inflight && credits_used == 3'd0) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  fifo2_tagged u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (inflight),
    .push_data (mem_rdata),
    .push_tag  (inflight_tag),
    .pop       (pop),
    .head_data (head_data),
    .head_tag  (head_tag),
    .count     (fifo_count)
  );

  assign out_s.valid      = (fifo_count != 2'd0);
  assign out_s.data       = head_data;
  assign out_s.row        = head_tag.row;
  assign out_s.col        = head_tag.col;
  assign out_s.last_mb    = head_tag.last_mb;
  assign out_s.last_frame = head_tag.last_frame;

endmodule
